e1of2_sync_tx: RTL and testbench

//  Clocked injector: encodes synchronous valid/ready words onto a 4-phase, enable-based dual-rail
//  (e1of2, M digits) channel feeding a router/decoder input (Pin/C1in/C2in style port).

---
 rtl/e1of2_sync_tx_pkg.sv | 25 ++
 rtl/e1of2_sync_tx_if.sv | 32 +++
 rtl/e1of2_sync_tx_fifo.sv | 82 ++++++++
 rtl/e1of2_sync_tx.sv | 127 ++++++++++++
 tb/tb_e1of2_sync_tx.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/e1of2_sync_tx_pkg.sv
// ---------------------------------------------------------------------------
// Package: e1of2_pkg
// Shared types and helpers for the synchronous-to-e1of2 injector and its
// matching receiver.
//   tx_state_t     : injector handshake state
//   NEUTRAL        : {t,f} rail pair of one digit in the spacer (return-to-zero) phase
//   e1of2_encode() : one data bit -> {t,f} rail pair of one dual-rail digit
// ---------------------------------------------------------------------------
package e1of2_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,  // rails neutral, waiting for a word and an enable
    TX_SEND = 2'd1,  // rails carry the FIFO head word
    TX_RTZ  = 2'd2   // rails neutral, waiting for the receiver to re-enable
  } tx_state_t;

  localparam logic [1:0] NEUTRAL = '0;

  // One digit: t follows the bit, f its complement. A valid codeword never has
  // both rails high; the all-zero pair is reserved for the spacer.
  function automatic logic [1:0] e1of2_encode(input logic d);
    return {d, ~d};
  endfunction

endpackage

// File: rtl/e1of2_sync_tx_if.sv
// ---------------------------------------------------------------------------
// Interface: e1of2_sync_tx_if
// Groups the valid/ready word input and the e1of2 output channel.
//   in_valid / in_ready / in_data : synchronous word sink
//   out_t / out_f                 : true / false rails, one pair per digit
//   out_e                         : asynchronous receiver enable (1 = ready)
// Modports:
//   slave  : the injector
//   master : the host side (word source plus receiver model)
// ---------------------------------------------------------------------------
interface e1of2_sync_tx_if #(
  parameter int M = 9
);

  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] in_data;
  logic [M-1:0] out_t;
  logic [M-1:0] out_f;
  logic         out_e;

  modport slave (
    input  in_valid, in_data, out_e,
    output in_ready, out_t, out_f
  );

  modport master (
    output in_valid, in_data, out_e,
    input  in_ready, out_t, out_f
  );

endinterface

// File: rtl/e1of2_sync_tx_fifo.sv
// ---------------------------------------------------------------------------
// Module: sync_fifo
// Single-clock FIFO with show-ahead head and registered full/empty flags.
// Shared by the e1of2 injector and the matching receiver.
//   clk   : clock
//   rst   : synchronous active-high reset (empties the FIFO)
//   push  : write din (ignored while full)
//   din   : write data
//   pop   : drop the head entry (ignored while empty)
//   head  : oldest entry, valid whenever empty is low
//   full  : registered, no free entry
//   empty : registered, no stored entry
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          full_q;
  logic          empty_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop  & ~empty_q;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and
  // flags define which entries are meaningful, so stale data is never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/e1of2_sync_tx.sv
// ---------------------------------------------------------------------------
// Module: e1of2_sync_tx
// Injects words from a synchronous valid/ready source into a 4-phase,
// enable-based dual-rail (e1of2) channel of M digits.
//   CLK       : sole clock
//   RESET     : synchronous active-high reset
//   bus       : e1of2_sync_tx_if.slave
//               in_valid/in_ready/in_data : word sink, buffered by a FIFO
//               out_t/out_f               : rails, driven straight from flops
//               out_e                     : async receiver enable, synchronised
//   tx_count  : completed 4-phase transfers, wraps at 2^CNT_W
//   busy      : FIFO holds a word or a transfer is in progress
// ---------------------------------------------------------------------------
module e1of2_sync_tx
  import e1of2_pkg::*;
#(
  parameter int M           = 9,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  e1of2_sync_tx_if.slave   bus,
  output logic [CNT_W-1:0] tx_count,
  output logic             busy
);

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [M-1:0] fifo_head;

  // Ready comes from the registered full flag, so a pop on a full FIFO only
  // opens a slot after the edge. It is held low while RESET is applied.
  assign bus.in_ready = ~fifo_full & ~RESET;
  assign fifo_push    = bus.in_valid & bus.in_ready;

  sync_fifo #(
    .W     (M),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (fifo_push),
    .din   (bus.in_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Enable synchroniser: out_e is asynchronous to CLK.
  logic [SYNC_STAGES-1:0] e_sync;
  logic                   e_s;

  always_ff @(posedge CLK) begin
    if (RESET) e_sync <= '0;
    else       e_sync <= {e_sync[SYNC_STAGES-2:0], bus.out_e};
  end

  assign e_s = e_sync[SYNC_STAGES-1];

  // Handshake FSM. Rails are flops that change only on IDLE->SEND (load word)
  // and SEND->RTZ (spacer), so the receiver never sees a partially updated word.
  tx_state_t        state_q;
  tx_state_t        state_d;
  logic [M-1:0]     t_q;
  logic [M-1:0]     f_q;
  logic [M-1:0]     t_d;
  logic [M-1:0]     f_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    f_d      = f_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty && e_s) begin
          state_d = TX_SEND;
          for (int i = 0; i < M; i++) {t_d[i], f_d[i]} = e1of2_encode(fifo_head[i]);
        end
      end
      TX_SEND: begin
        // Receiver withdrew enable: it has captured the word.
        if (!e_s) begin
          state_d  = TX_RTZ;
          fifo_pop = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          for (int i = 0; i < M; i++) {t_d[i], f_d[i]} = NEUTRAL;
        end
      end
      TX_RTZ: begin
        if (e_s) state_d = TX_IDLE;
      end
      default: begin
        state_d = TX_IDLE;
        for (int i = 0; i < M; i++) {t_d[i], f_d[i]} = NEUTRAL;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= TX_IDLE;
      t_q     <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_t = t_q;
  assign bus.out_f = f_q;
  assign tx_count  = cnt_q;
  assign busy      = ~fifo_empty | (state_q != TX_IDLE);

endmodule

// File: tb/tb_e1of2_sync_tx.sv
// ---------------------------------------------------------------------------
// Testbench: tb_e1of2_sync_tx
// Words accepted by the injector are queued as expected traffic; a receiver
// process plays the 4-phase protocol on out_e, pops and compares every word it
// sees on the rails, and counts completed transfers. A narrow tx_count makes
// counter wrap-around happen within a short run.
// ---------------------------------------------------------------------------
module tb_e1of2_sync_tx;

  localparam int M           = 9;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  e1of2_sync_tx_if #(.M(M)) bus ();

  logic [CNT_W-1:0] tx_count;
  logic             busy;

  // out_e comes either from the automatic receiver or from directed tests.
  logic rx_auto = 1'b0;
  logic rx_e    = 1'b1;
  logic man_e   = 1'b1;
  assign bus.out_e = rx_auto ? rx_e : man_e;

  e1of2_sync_tx #(
    .M           (M),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK      (clk),
    .RESET    (reset),
    .bus      (bus),
    .tx_count (tx_count),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: words still owed to the receiver, and the number
  // of transfers the receiver has completed since the last reset.
  logic [M-1:0] exp_q[$];
  int           model_count = 0;

  typedef enum {R_READY, R_HOLD, R_DROP, R_RTZ} rx_state_t;
  rx_state_t rx_state = R_READY;

  function automatic logic rails_legal(input logic [M-1:0] t, input logic [M-1:0] f);
    logic [M-1:0] all1 = '1;
    return ((t & f) == '0) && (((t | f) == '0) || ((t | f) == all1));
  endfunction

  // Receiver model / monitor.
  initial begin
    logic [M-1:0] t, f, w, w_f, held_t, held_f;
    int           delay;
    delay = 0;
    held_t = '0;
    held_f = '0;
    forever begin
      @(negedge clk);
      t = bus.out_t;
      f = bus.out_f;
      check("rails_legal", 32'(rails_legal(t, f)), 32'd1);
      if (reset) begin
        rx_state    = R_READY;
        rx_e        = 1'b1;
        model_count = 0;
      end else if (rx_auto) begin
        case (rx_state)
          R_READY: begin
            rx_e = 1'b1;
            if ((t | f) != '0) begin
              if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(t), 32'hFFFF_FFFF);
              end else begin
                w   = exp_q.pop_front();
                w_f = ~w;
                check("word_t", 32'(t), 32'(w));
                check("word_f", 32'(f), 32'(w_f));
              end
              held_t   = t;
              held_f   = f;
              delay    = $urandom_range(0, 7);
              rx_state = R_HOLD;
            end
          end
          R_HOLD: begin
            check("hold_stable_t", 32'(t), 32'(held_t));
            check("hold_stable_f", 32'(f), 32'(held_f));
            if (delay == 0) begin
              rx_e     = 1'b0;
              rx_state = R_DROP;
            end else begin
              delay--;
            end
          end
          R_DROP: begin
            if ((t | f) == '0) begin
              model_count++;
              check("tx_count", 32'(tx_count), 32'(model_count % (1 << CNT_W)));
              delay    = $urandom_range(0, 7);
              rx_state = R_RTZ;
            end else begin
              check("drop_stable_t", 32'(t), 32'(held_t));
            end
          end
          R_RTZ: begin
            check("rtz_neutral", 32'(t | f), 32'd0);
            if (delay == 0) begin
              rx_e     = 1'b1;
              rx_state = R_READY;
            end else begin
              delay--;
            end
          end
          default: rx_state = R_READY;
        endcase
      end
    end
  end

  task automatic push(input logic [M-1:0] d, input bit track, output bit acc);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    acc          = bus.in_ready;
    @(posedge clk);
    if (acc && track) exp_q.push_back(d);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_out_t", 32'(bus.out_t), 32'd0);
    check("rst_out_f", 32'(bus.out_f), 32'd0);
    check("rst_tx_count", 32'(tx_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    bit ok;
    n  = 0;
    ok = (exp_q.size() == 0) && (rx_state == R_READY) && (busy == 1'b0);
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      ok = (exp_q.size() == 0) && (rx_state == R_READY) && (busy == 1'b0);
    end
    check("drain_done", 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit           acc;
    logic [M-1:0] w;
    int           tries;
    bit           seen;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // 1: single word with manual enable, exact latency and encoding.
    rx_auto = 1'b0;
    man_e   = 1'b1;
    do_reset();
    repeat (SYNC_STAGES + 1) @(negedge clk);
    push(9'h1A5, 1'b0, acc);
    check("t1_accept", 32'(acc), 32'd1);
    @(negedge clk);
    check("t1_neutral_edge_k", 32'(bus.out_t | bus.out_f), 32'd0);
    @(negedge clk);
    check("t1_out_t", 32'(bus.out_t), 32'h1A5);
    check("t1_out_f", 32'(bus.out_f), 32'h05A);
    man_e = 1'b0;
    for (int i = 0; i < SYNC_STAGES; i++) begin
      @(negedge clk);
      check("t1_hold_t", 32'(bus.out_t), 32'h1A5);
    end
    @(negedge clk);
    check("t1_neutral", 32'(bus.out_t | bus.out_f), 32'd0);
    check("t1_tx_count", 32'(tx_count), 32'd1);
    man_e = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // 2: enable held low, five pushes into a four-entry FIFO.
    man_e = 1'b0;
    do_reset();
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      w = M'($urandom);
      push(w, 1'b1, acc);
      check("t2_accept", 32'(acc), (i < FIFO_DEPTH) ? 32'd1 : 32'd0);
      if (i == FIFO_DEPTH - 1) begin
        @(negedge clk);
        check("t2_full_ready", 32'(bus.in_ready), 32'd0);
      end
      check("t2_rails_neutral", 32'(bus.out_t | bus.out_f), 32'd0);
    end
    check("t2_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rx_auto = 1'b1;
    drain(400);

    // 3: back-to-back burst, then random traffic with random receiver delays.
    for (int i = 0; i < 4; i++) begin
      w = M'($urandom);
      push(w, 1'b1, acc);
      check("t3_burst_accept", 32'(acc), 32'd1);
    end
    for (int i = 0; i < 30; i++) begin
      w     = M'($urandom);
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 200) begin
        push(w, 1'b1, acc);
        tries++;
      end
      check("t3_accept_bound", 32'(acc), 32'd1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain(3000);

    // 4: reset while a word is on the rails, with more words queued behind it.
    @(posedge clk);
    #1 rx_auto = 1'b0;
    man_e = 1'b1;
    push(9'h0FF, 1'b0, acc);
    push(9'h123, 1'b0, acc);
    push(9'h0AA, 1'b0, acc);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = ((bus.out_t | bus.out_f) != '0);
    end
    check("t4_word_seen", 32'(seen), 32'd1);
    check("t4_out_t", 32'(bus.out_t), 32'h0FF);
    check("t4_out_f", 32'(bus.out_f), 32'h100);
    do_reset();
    repeat (10) @(negedge clk);
    check("t4_no_resend", 32'(bus.out_t | bus.out_f), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_tx_count", 32'(tx_count), 32'd0);

    // 6: one-cycle enable glitch while idle and empty, then a real transfer.
    @(negedge clk);
    man_e = 1'b0;
    @(negedge clk);
    man_e = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_tx_count", 32'(tx_count), 32'd0);
    check("t6_neutral", 32'(bus.out_t | bus.out_f), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rx_auto = 1'b1;
    push(M'($urandom), 1'b1, acc);
    check("t6_accept", 32'(acc), 32'd1);
    drain(400);
    check("t6_final_count", 32'(tx_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
